// File: rtl/alu_pkg.sv
// Shared ALU decode constants: ALU control codes, main-decoder alu_op
// encodings, RV32M funct3 values and the multiply/divide sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_PASS = 4'b1111
  } alu_ctrl_t;

  localparam logic [1:0] AOP_LDST   = 2'b00;
  localparam logic [1:0] AOP_BRANCH = 2'b01;
  localparam logic [1:0] AOP_RTYPE  = 2'b10;
  localparam logic [1:0] AOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Execute-stage decode/issue bundle between ID/EX register and alu_ctrl_seq.
interface alu_ctrl_seq_if #(parameter int XLEN = 32);
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            req_valid;
  logic            kill;
  logic            req_ready;
  logic [3:0]      alu_control;
  logic            illegal;
  logic            stall;
  logic            md_valid;
  logic [XLEN-1:0] md_result;

  modport master (
    output alu_op, funct3, funct7, a, b, req_valid, kill,
    input  req_ready, alu_control, illegal, stall, md_valid, md_result
  );

  modport slave (
    input  alu_op, funct3, funct7, a, b, req_valid, kill,
    output req_ready, alu_control, illegal, stall, md_valid, md_result
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath on unsigned magnitudes.
// Multiply: radix-2 shift-add, {hi,lo} ends as the 2*XLEN product.
// Divide: restoring division, lo ends as quotient and hi as remainder.
module muldiv_iter #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            last,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [5:0]      cnt;
  logic            mode_div;
  logic [XLEN-1:0] opb;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;

  // Partial-product add and trial subtract. The remainder stays below the
  // divisor, so the shifted remainder fits XLEN+1 bits and diff's MSB is a
  // valid borrow flag.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    diff = {hi, lo[XLEN-1]} - {1'b0, opb};
  end

  assign last = busy && (cnt == 6'(XLEN - 1));

  // Operand load, one iteration per cycle, stop after XLEN iterations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      cnt      <= '0;
      mode_div <= 1'b0;
      opb      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (clear) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      mode_div <= is_div;
      opb      <= op_b;
      hi       <= '0;
      lo       <= op_a;
    end else if (busy) begin
      if (mode_div) begin
        if (!diff[XLEN]) begin
          hi <= diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= {hi[XLEN-2:0], lo[XLEN-1]};
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi, lo} <= {sum, lo[XLEN-1:1]};
      end
      cnt <= cnt + 6'd1;
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decode plus RV32M multiply/divide sequencer.
// Define ALU_CTRL_RV32M_EN to build the M engine; without it M ops decode
// as illegal and the sequencer outputs are tied off.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_seq_if.slave bus
);

  alu_ctrl_t ctrl;
  logic      ill;
  logic      m_op;

  // Base decode, purely combinational and independent of sequencer state.
  always_comb begin
    m_op = (bus.alu_op == AOP_RTYPE) && (bus.funct7 == F7_MULDIV);
    ctrl = ALU_PASS;
    ill  = 1'b0;
    case (bus.alu_op)
      AOP_LDST:   ctrl = ALU_ADD;
      AOP_BRANCH: ctrl = ALU_SUB;
      AOP_RTYPE: begin
        if (m_op) begin
          ctrl = ALU_PASS;
`ifdef ALU_CTRL_RV32M_EN
          ill  = 1'b0;
`else
          ill  = 1'b1;
`endif
        end else begin
          case (bus.funct3)
            3'b000:  ctrl = bus.funct7[5] ? ALU_SUB : ALU_ADD;
            3'b111:  ctrl = ALU_AND;
            3'b110:  ctrl = ALU_OR;
            default: ill  = 1'b1;
          endcase
        end
      end
      default: begin
        case (bus.funct3)
          3'b000:  ctrl = ALU_ADD;
          3'b111:  ctrl = ALU_AND;
          3'b110:  ctrl = ALU_OR;
          default: ill  = 1'b1;
        endcase
      end
    endcase
  end

  assign bus.alu_control = ctrl;
  assign bus.illegal     = ill;

`ifdef ALU_CTRL_RV32M_EN
  md_state_t         state;
  logic [2:0]        f3_q;
  logic              neg_a_q;
  logic              neg_res_q;
  logic              divzero_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   md_result_q;
  logic              a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              accept, b_zero, is_div, start;
  logic              eng_busy, eng_last;
  logic [XLEN-1:0]   eng_hi, eng_lo;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, fixed;

  // Operand signedness per M op, and magnitudes fed to the engine.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU:                a_signed = 1'b1;
      F3_MULHU, F3_DIVU, F3_REMU: a_signed = 1'b0;
      default:                  a_signed = 1'b0;
    endcase
    neg_a  = a_signed & bus.a[XLEN-1];
    neg_b  = b_signed & bus.b[XLEN-1];
    a_mag  = neg_a ? -bus.a : bus.a;
    b_mag  = neg_b ? -bus.b : bus.b;
    b_zero = (bus.b == '0);
    is_div = bus.funct3[2];
    accept = bus.req_valid && (state == MD_IDLE) && m_op && !bus.kill;
    start  = accept && !(is_div && b_zero);
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (bus.kill),
    .start  (start),
    .is_div (is_div),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .busy   (eng_busy),
    .last   (eng_last),
    .hi     (eng_hi),
    .lo     (eng_lo)
  );

  // Sign fix-up of the magnitude result; divide-by-zero bypasses the engine.
  always_comb begin
    prod_s = neg_res_q ? -{eng_hi, eng_lo} : {eng_hi, eng_lo};
    quo    = neg_res_q ? -eng_lo : eng_lo;
    rem    = neg_a_q ? -eng_hi : eng_hi;
    if (!f3_q[2])
      fixed = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (divzero_q)
      fixed = f3_q[1] ? a_q : '1;
    else
      fixed = f3_q[1] ? rem : quo;
  end

  // Sequencer: accept, run the engine, present the result for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MD_IDLE;
      f3_q        <= '0;
      neg_a_q     <= 1'b0;
      neg_res_q   <= 1'b0;
      divzero_q   <= 1'b0;
      a_q         <= '0;
      md_result_q <= '0;
    end else if (bus.kill) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            f3_q      <= bus.funct3;
            neg_a_q   <= neg_a;
            neg_res_q <= neg_a ^ neg_b;
            divzero_q <= is_div && b_zero;
            a_q       <= bus.a;
            if (!is_div)     state <= MD_MUL;
            else if (b_zero) state <= MD_DONE;
            else             state <= MD_DIV;
          end
        end
        MD_MUL, MD_DIV: begin
          if (eng_last) state <= MD_DONE;
        end
        MD_DONE: begin
          md_result_q <= fixed;
          state       <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // md_result shows the fresh value during DONE, then holds it in md_result_q.
  assign bus.req_ready = (state == MD_IDLE);
  assign bus.stall     = (state == MD_MUL) || (state == MD_DIV) ||
                         ((state == MD_IDLE) && bus.req_valid && m_op);
  assign bus.md_valid  = (state == MD_DONE) && !bus.kill;
  assign bus.md_result = bus.md_valid ? fixed : md_result_q;

  logic unused_eng;
  assign unused_eng = eng_busy;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst_n, bus.a, bus.b, bus.req_valid, bus.kill};

  assign bus.req_ready = 1'b1;
  assign bus.stall     = 1'b0;
  assign bus.md_valid  = 1'b0;
  assign bus.md_result = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: M-op results are queued when issued and
// checked by a monitor on md_valid; decode and timing are checked inline.
// Covers both builds, selected by ALU_CTRL_RV32M_EN.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.XLEN(32)) bus ();

  alu_ctrl_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every md_valid pulse must match the oldest issued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.md_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_md_valid", 32'd1, 32'd0);
      else check("md_result", bus.md_result, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic dec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [3:0] ec, input logic ei);
    bus.alu_op = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    @(negedge clk);
    check("alu_control", {28'd0, bus.alu_control}, {28'd0, ec});
    check("illegal", {31'd0, bus.illegal}, {31'd0, ei});
  endtask

  // Issue one M op at posedge+1 (cycle 0) and check handshake timing.
  // Ends at posedge+1 so the next request can be driven immediately.
  task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int c;
    logic got, bad_stall;
    exp_q.push_back(exp);
    bus.alu_op = 2'b10;
    bus.funct3 = f3;
    bus.funct7 = 7'b0000001;
    bus.a = a;
    bus.b = b;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_c0", {31'd0, bus.req_ready}, 32'd1);
    check("stall_c0", {31'd0, bus.stall}, 32'd1);
    check("alu_control_mop", {28'd0, bus.alu_control}, 32'hF);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    c = 0;
    got = 1'b0;
    bad_stall = 1'b0;
    while (c < 40 && !got) begin
      @(negedge clk);
      c++;
      if (bus.md_valid === 1'b1) got = 1'b1;
      else if (bus.stall !== 1'b1) bad_stall = 1'b1;
    end
    check("md_valid_cycle", 32'(c), 32'(lat));
    check("stall_window", {31'd0, bad_stall}, 32'd0);
    check("stall_done", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    check("md_valid_one_cycle", {31'd0, bus.md_valid}, 32'd0);
    check("req_ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("md_result_hold", bus.md_result, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.alu_op = 2'b00;
    bus.funct3 = 3'b000;
    bus.funct7 = 7'b0000000;
    bus.a = '0;
    bus.b = '0;
    bus.req_valid = 1'b0;
    bus.kill = 1'b0;
    #2;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_md_valid", {31'd0, bus.md_valid}, 32'd0);
    check("rst_md_result", bus.md_result, 32'd0);
    #10 rst_n = 1'b1;

    // Base decode vectors
    dec(2'b00, 3'b010, 7'b0000000, 4'b0010, 1'b0);
    dec(2'b01, 3'b000, 7'b0000000, 4'b0110, 1'b0);
    dec(2'b10, 3'b000, 7'b0000000, 4'b0010, 1'b0);
    dec(2'b10, 3'b000, 7'b0100000, 4'b0110, 1'b0);
    check("stall_rtype_sub", {31'd0, bus.stall}, 32'd0);
    dec(2'b10, 3'b111, 7'b0000000, 4'b0000, 1'b0);
    dec(2'b10, 3'b110, 7'b0000000, 4'b0001, 1'b0);
    dec(2'b10, 3'b001, 7'b0000000, 4'b1111, 1'b1);
    dec(2'b10, 3'b101, 7'b0100000, 4'b1111, 1'b1);
    dec(2'b11, 3'b000, 7'b0100000, 4'b0010, 1'b0);
    dec(2'b11, 3'b111, 7'b0000000, 4'b0000, 1'b0);
    dec(2'b11, 3'b110, 7'b0000000, 4'b0001, 1'b0);
    dec(2'b11, 3'b010, 7'b0000000, 4'b1111, 1'b1);

`ifdef ALU_CTRL_RV32M_EN
    dec(2'b10, 3'b000, 7'b0000001, 4'b1111, 1'b0);
    @(posedge clk);
    #1;
    run_m(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33); // MULH
    run_m(3'b000, 32'd7,         32'd6,         32'h0000_002A, 33); // MUL
    run_m(3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33); // MUL -3*5
    run_m(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33); // MULHU
    run_m(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33); // MULHSU
    run_m(3'b010, 32'd2,         32'hFFFF_FFFF, 32'h0000_0001, 33); // MULHSU
    run_m(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33); // DIV ovf
    run_m(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33); // REM ovf
    run_m(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33); // DIV -7/2
    run_m(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33); // REM -7/2
    run_m(3'b101, 32'd100,       32'd7,         32'h0000_000E, 33); // DIVU
    run_m(3'b111, 32'd100,       32'd7,         32'h0000_0002, 33); // REMU
    run_m(3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33); // DIVU /1
    run_m(3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, 1);  // DIVU /0
    run_m(3'b111, 32'd7,         32'd0,         32'h0000_0007, 1);  // REMU /0
    run_m(3'b100, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1);  // DIV /0
    run_m(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);  // REM /0

    // Kill during cycle 10 of a MUL; a new request goes in at cycle 11.
    bus.alu_op = 2'b10;
    bus.funct3 = 3'b000;
    bus.funct7 = 7'b0000001;
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(negedge clk);
    check("kill_stall_c10", {31'd0, bus.stall}, 32'd1);
    check("kill_md_valid", {31'd0, bus.md_valid}, 32'd0);
    @(posedge clk);
    #1 bus.kill = 1'b0;
    run_m(3'b000, 32'd3, 32'd5, 32'h0000_000F, 33);

    // Asynchronous reset in the middle of a DIV.
    bus.alu_op = 2'b10;
    bus.funct3 = 3'b100;
    bus.funct7 = 7'b0000001;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    check("mid_rst_md_valid", {31'd0, bus.md_valid}, 32'd0);
    check("mid_rst_md_result", bus.md_result, 32'd0);
    #3 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`else
    dec(2'b10, 3'b000, 7'b0000001, 4'b1111, 1'b1);
    bus.a = 32'd7;
    bus.b = 32'd6;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("off_stall", {31'd0, bus.stall}, 32'd0);
      check("off_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("off_md_valid", {31'd0, bus.md_valid}, 32'd0);
      check("off_md_result", bus.md_result, 32'd0);
    end
    bus.req_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Decode and issue front-end for the execute stage: turns main-decoder `alu_op` plus `funct3`/`funct7` into the 4-bit ALU control code for base RV32I operations. It also sequences RV32M multiply/divide operations on an internal iterative engine. It sits between the ID/EX register and the ALU, and raises `stall` to the hazard unit while an M operation is in flight.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `alu_op`  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- `funct3`  in  3  instruction funct3.
- `funct7`  in  7  instruction funct7; only bit 5 and the 0000001 pattern are used.
- `a`, `b`  in  32  rs1 and rs2 operand values (used by the M engine only).
- `req_valid`  in  1  instruction fields are valid this cycle.
- `kill`  in  1  pipeline flush; abandons any in-flight M operation.
- `req_ready`  out  1  high in IDLE only.
- `alu_control`  out  4  code to the ALU: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 unsupported (ALU passes `a`).
- `illegal`  out  1  combinational; the decoded op is unsupported.
- `stall`  out  1  hold upstream stages.
- `md_valid`  out  1  one-cycle pulse; `md_result` is valid.
- `md_result`  out  32  M-operation result.

## Operation
- Base decode is purely combinational and independent of state:
  - `alu_op`=00 gives ADD.
  - `alu_op`=01 gives SUB.
  - `alu_op`=10: funct3 000 gives ADD, or SUB when funct7[5]=1; 111 gives AND; 110 gives OR; anything else gives 1111 with `illegal`=1.
  - `alu_op`=11: funct3 000/111/110 give ADD/AND/OR; anything else gives 1111 with `illegal`=1.
- An M op is `alu_op`=10 with `funct7`=0000001. While an M op is presented, `alu_control`=1111.
- An M op is accepted on `req_valid & req_ready & m_op`. Operands are latched on acceptance.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE goes to MUL when funct3[2]=0.
  - IDLE goes to DIV when funct3[2]=1 and the divisor is nonzero.
  - IDLE goes directly to DONE when funct3[2]=1 and the divisor is zero.
  - MUL and DIV each run 32 iterations, then go to DONE.
  - DONE goes to IDLE unconditionally.
- MUL uses radix-2 shift-add on magnitudes with a 64-bit product.
  - Sign handling: MUL/MULH are signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned.
  - MUL returns product[31:0]; the other three return product[63:32].
- DIV uses restoring division on magnitudes, followed by sign fix-up.
  - Quotient takes the XOR of the operand signs; remainder takes the dividend sign.
  - DIV/REM are signed; DIVU/REMU are unsigned.
- Boundary cases:
  - Divide by zero: quotient is 0xFFFFFFFF; remainder is the dividend.
  - Signed overflow (0x80000000 / −1): quotient is 0x80000000; remainder is 0. This case runs the full 32 iterations.
  - `stall` = (state≠IDLE & state≠DONE) | (IDLE & `req_valid` & m_op).
- `kill` in any state forces IDLE on the next edge. No `md_valid` is produced, and `kill` takes priority over DONE.
- A `req_valid` arriving while `req_ready`=0 is ignored; upstream must hold it because `stall` is asserted.

## Timing
- Reset values: state IDLE, `md_valid`=0, `md_result`=0, `req_ready`=1, `stall`=0. Internal registers are also cleared.
- Reset asserted mid-operation aborts immediately; no response is produced.
- Base ops: zero latency.
- MUL/DIV: accepted at edge 0, iterations on edges 1–32, DONE state during cycle 33. `md_valid`=1 for exactly that one cycle. `req_ready` returns to 1 in cycle 34.
- Divide by zero: DONE during cycle 1.
- `md_result` holds its value after DONE until the next DONE.

## Configuration
- `ALU_CTRL_RV32M_EN` defined: the M engine and FSM are compiled in as described above.
- `ALU_CTRL_RV32M_EN` undefined:
  - M ops decode as `alu_control`=1111 with `illegal`=1.
  - `stall`, `md_valid` and `md_result` are tied to 0; `req_ready` is tied to 1.
  - No state registers are present.

## Structure
- Shared package `alu_pkg` holds:
  - The `alu_ctrl_t` 4-bit codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASS).
  - The `alu_op` encodings.
  - The funct3 M-op constants.
  - The `md_state_t` enum.
- Sub-module `muldiv_iter` holds the shared shift/accumulate datapath and the 6-bit iteration counter. `alu_ctrl_seq` holds decode, the FSM and sign fix-up.

## Test plan
- Base decode:
  - `alu_op`=10, funct3=000, funct7=0100000 gives `alu_control`=0110, `stall`=0.
  - `alu_op`=11, funct3=110 gives 0001.
  - funct3=001 with `alu_op`=10 gives 1111 and `illegal`=1.
- MULH with a=0xFFFFFFFF, b=0x00000002: `md_result`=0xFFFFFFFF, `md_valid` in cycle 33, `stall` high in cycles 0–32.
- DIV with a=0x80000000, b=0xFFFFFFFF gives 0x80000000. REM with the same operands gives 0.
- DIVU with a=7, b=0 gives 0xFFFFFFFF and `md_valid` in cycle 1. REMU with a=7, b=0 gives 7.
- `kill` at cycle 10 of a MUL: IDLE at cycle 11, no `md_valid`. A new request is accepted in cycle 11.
- `rst_n` low mid-DIV: outputs return to their reset values asynchronously. With the macro undefined, MUL decodes as `illegal`=1.
